// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-oriented UART serializer among NCH
// requesting channels. A granted channel's byte is latched and acked at once.
// An optional channel-ID header byte (8'hA0 | id) is sent first, then the
// payload. Each frame is handed over with a one-cycle tx_start, and the
// scheduler waits for tx_done before moving on.
module uart_tx_scheduler #(
  parameter int NCH       = 4,
  parameter bit ID_HEADER = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*8-1:0]        data,
  output logic [NCH-1:0]          ack,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    busy
);
  localparam int GW = $clog2(NCH);

  typedef enum logic [2:0] {
    IDLE, HDR_START, HDR_WAIT, DAT_START, DAT_WAIT
  } state_t;

  state_t                 state;
  logic [GW-1:0]          ptr;
  logic [GW-1:0]          winner;
  logic [7:0]             data_q;
  logic [NCH-1:0][7:0]    lanes;
  logic [NCH-1:0]         hi_req;

  assign lanes = data;

  // Round-robin pick: the lowest requester above ptr wins. If there is none,
  // the search wraps and the lowest requester overall wins.
  always_comb begin
    hi_req = '0;
    winner = ptr;
    for (int i = 0; i < NCH; i++) begin
      hi_req[i] = req[i] && (i > int'(ptr));
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) winner = GW'(i);
    end
    if (|hi_req) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (hi_req[i]) winner = GW'(i);
      end
    end
  end

  // Message FSM. Every output is a register, so nothing combinational runs
  // from req/data/tx_done to the outputs. tx_done is only heeded in the WAIT
  // states, so a stray pulse in IDLE or in a START cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= GW'(NCH - 1);
      grant_id <= '0;
      data_q   <= 8'h00;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            ptr         <= winner;
            grant_id    <= winner;
            data_q      <= lanes[winner];
            ack[winner] <= 1'b1;
            tx_start    <= 1'b1;
            busy        <= 1'b1;
            if (ID_HEADER) begin
              state   <= HDR_START;
              tx_data <= 8'hA0 | 8'(winner);
            end else begin
              state   <= DAT_START;
              tx_data <= lanes[winner];
            end
          end
        end
        HDR_START: state <= HDR_WAIT;
        HDR_WAIT: begin
          if (tx_done) begin
            state    <= DAT_START;
            tx_start <= 1'b1;
            tx_data  <= data_q;
          end
        end
        DAT_START: state <= DAT_WAIT;
        DAT_WAIT: begin
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. Two instances run side by side: one with
// NCH=4 and the ID header, and one with NCH=5 and payload only. A
// transaction-level model predicts, per clock edge, which channel is granted
// and which bytes are framed. A monitor pops those predictions and compares
// them against the DUT outputs.
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   mode = 0;  // 0 burst from reset, 1 random, 2 drain, 3 raise ch3 only

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  task automatic chk(input int inst, input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL g%0d %s: got %0h expected %0h (cycle %0d)", inst, name, act, exp, cyc);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int N   = (d == 0) ? 4 : 5;
    localparam bit HDR = (d == 0);
    localparam int GW  = $clog2(N);

    logic [N-1:0]        req = '0;
    logic [N-1:0][7:0]   lanes = '0;
    logic                tx_done = 1'b0;
    logic [N-1:0]        ack;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic [GW-1:0]       grant_id;
    logic                busy;

    uart_tx_scheduler #(.NCH(N), .ID_HEADER(HDR)) dut (
      .clk(clk), .rst(rst), .req(req), .data(lanes), .ack(ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
      .grant_id(grant_id), .busy(busy)
    );

    // model state: message in flight, frames still owed, last grant
    int ptr = N - 1;
    int frames_left = 0;
    int gid = 0;
    int exp_txd = 0;
    int pend_data = 0;
    bit mbusy = 1'b0;
    bit in_start = 1'b0;
    bit exp_busy = 1'b0;
    int ack_q[$];
    int start_q[$];
    int grants[$];
    int txlog[$];
    int raised = 0;

    // reference model: evaluated on the inputs present at each rising edge
    initial forever begin
      int w, idx, dbyte;
      bit found;
      @(posedge clk);
      if (rst) begin
        ptr = N - 1; frames_left = 0; gid = 0; exp_txd = 0;
        mbusy = 1'b0; in_start = 1'b0; exp_busy = 1'b0;
        ack_q.delete(); start_q.delete();
      end else begin
        if (mbusy) begin
          if (in_start) in_start = 1'b0;
          else if (tx_done) begin
            frames_left--;
            if (frames_left > 0) begin
              start_q.push_back(pend_data);
              exp_txd = pend_data;
              in_start = 1'b1;
            end else begin
              mbusy = 1'b0;
            end
          end
        end else if (|req) begin
          w = ptr; found = 1'b0;
          for (int i = 1; i <= N; i++) begin
            idx = (ptr + i) % N;
            if (!found && req[idx[GW-1:0]]) begin w = idx; found = 1'b1; end
          end
          dbyte = int'(lanes[w[GW-1:0]]);
          ptr = w; gid = w; mbusy = 1'b1; in_start = 1'b1;
          ack_q.push_back(w);
          if (HDR) begin
            start_q.push_back(32'hA0 | w);
            exp_txd = 32'hA0 | w;
            pend_data = dbyte;
            frames_left = 2;
          end else begin
            start_q.push_back(dbyte);
            exp_txd = dbyte;
            frames_left = 1;
          end
        end
        exp_busy = mbusy;
      end
    end

    // monitor: checks DUT outputs just after each edge against the model
    initial forever begin
      int e;
      @(posedge clk); #1;
      if (rst) begin
        chk(d, "rst_ack", int'(ack), 0);
        chk(d, "rst_tx_start", int'(tx_start), 0);
        chk(d, "rst_tx_data", int'(tx_data), 0);
        chk(d, "rst_grant_id", int'(grant_id), 0);
        chk(d, "rst_busy", int'(busy), 0);
      end else begin
        if (ack != '0 || ack_q.size() != 0) begin
          e = (ack_q.size() != 0) ? ack_q.pop_front() : -1;
          chk(d, "ack", int'(ack), (e < 0) ? 0 : (1 << e));
          for (int i = 0; i < N; i++) if (ack[i]) grants.push_back(i);
        end
        if (tx_start || start_q.size() != 0) begin
          e = (start_q.size() != 0) ? start_q.pop_front() : -1;
          chk(d, "tx_start", int'(tx_start), int'(e >= 0));
          if (e >= 0) chk(d, "tx_data_start", int'(tx_data), e);
          if (tx_start) txlog.push_back(int'(tx_data));
        end
        chk(d, "busy", int'(busy), int'(exp_busy));
        if (exp_busy) chk(d, "tx_data_hold", int'(tx_data), exp_txd);
        chk(d, "grant_id", int'(grant_id), gid);
      end
    end

    // serializer stand-in: real tx_done 2..12 cycles after tx_start, plus
    // stray pulses in the start cycle and while no frame is in flight
    initial begin
      int cnt;
      bit spur;
      cnt = 0;
      forever begin
        @(posedge clk); #1;
        spur = 1'b0;
        if (rst) cnt = 0;
        else if (tx_start) begin
          cnt  = $urandom_range(2, 12);
          spur = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        if (rst) tx_done = 1'b0;
        else if (cnt > 0) begin
          cnt--;
          tx_done = (cnt == 0) || spur;
        end else begin
          tx_done = !tx_done && ($urandom_range(0, 15) == 0);
        end
      end
    end

    // requesters: hold req until ack, then drop it and scramble the lane
    initial begin
      for (int i = 0; i < N; i++) lanes[i[GW-1:0]] = 8'h10 + 8'(i);
      req = '1;
      raised = N;
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (req[i[GW-1:0]] && ack[i[GW-1:0]]) begin
            req[i[GW-1:0]] = 1'b0;
          end else if (!req[i[GW-1:0]]) begin
            if (mode == 1 && $urandom_range(0, 7) == 0) begin
              lanes[i[GW-1:0]] = 8'($urandom);
              req[i[GW-1:0]] = 1'b1;
              raised++;
            end else if (mode == 3 && i == 3) begin
              lanes[i[GW-1:0]] = 8'h3C;
              req[i[GW-1:0]] = 1'b1;
              raised++;
            end else if ($urandom_range(0, 1) == 1) begin
              lanes[i[GW-1:0]] = 8'($urandom);
            end
          end
        end
      end
    end
  end

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // burst: every channel requested from reset is served once, in index order
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge clk);
      hit = (g[0].txlog.size() >= 8) && (g[1].txlog.size() >= 5)
            && !g[0].mbusy && !g[1].mbusy;
    end
    chk(0, "burst_done", int'(hit), 1);
    if (hit) begin
      chk(0, "burst_grants", g[0].grants.size(), 4);
      chk(1, "burst_grants", g[1].grants.size(), 5);
      for (int i = 0; i < 4; i++) begin
        chk(0, "rr_order", g[0].grants[i], i);
        chk(0, "burst_hdr", g[0].txlog[2*i], 32'hA0 + i);
        chk(0, "burst_data", g[0].txlog[2*i+1], 32'h10 + i);
      end
      for (int i = 0; i < 5; i++) begin
        chk(1, "rr_order", g[1].grants[i], i);
        chk(1, "burst_data", g[1].txlog[i], 32'h10 + i);
      end
    end

    mode = 1;
    repeat (3000) @(negedge clk);

    // abort a message in its data-wait phase with an asynchronous reset
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(posedge clk); #2;
      hit = g[0].mbusy && g[0].frames_left == 1 && !g[0].in_start
            && !(g[1].mbusy && g[1].in_start);
    end
    chk(0, "dat_wait_reached", int'(hit), 1);
    #1 rst = 1'b1;
    mode = 3;
    #1;
    chk(0, "arst_busy", int'(g[0].busy), 0);
    chk(0, "arst_tx_data", int'(g[0].tx_data), 0);
    chk(0, "arst_grant_id", int'(g[0].grant_id), 0);
    chk(1, "arst_busy", int'(g[1].busy), 0);
    chk(1, "arst_tx_start", int'(g[1].tx_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode = 1;
    repeat (2000) @(negedge clk);

    // drain: stop new requests and let everything pending complete
    mode = 2;
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge clk);
      hit = (g[0].req == '0) && !g[0].mbusy && (g[1].req == '0) && !g[1].mbusy;
    end
    chk(0, "drain_done", int'(hit), 1);
    chk(0, "acks_vs_reqs", g[0].grants.size(), g[0].raised);
    chk(1, "acks_vs_reqs", g[1].grants.size(), g[1].raised);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
